param_router: RTL and testbench
===============================

// Module: param_router
// PURPOSE
//  NUM_PORTS x NUM_PORTS wormhole router, the parametrised successor of the 2x2 router.
//  Per-input FIFO, per-output round-robin arbiter with packet lock, output backpressure, registered outputs.
//  Sits between mesh links. Flits of one packet are never interleaved with another packet's flits on an output.
// PARAMETERS
//  NUM_PORTS   4  number of input and output ports, 2..8 (bounded by router_pkg::DEST_W=3)
//  FIFO_DEPTH  4  entries per input FIFO; power of 2, >=2
// PORTS
//  clk            in   1                   clock
//  rst_b          in   1                   synchronous active-low reset
//  pkt_in         in   NUM_PORTS x flit    pkt_in[i].valid = write flit into FIFO i
//  out_ready      in   NUM_PORTS           sink j can take a flit next cycle
//  pkt_out        out  NUM_PORTS x flit    registered output flit per port
//  fifo_full      out  NUM_PORTS           FIFO i is full; upstream must not write
//  overflow_err   out  NUM_PORTS           1-cycle pulse: write to full FIFO i was dropped
//  misroute_err   out  NUM_PORTS           1-cycle pulse: head of FIFO i had dest>=NUM_PORTS and was dropped
// BEHAVIOUR
//  Clock and reset: one clock, clk. rst_b is synchronous and active-low.
//  Reset: all FIFOs empty, locks clear, RR pointers=0. pkt_out='0, fifo_full=0, err pulses=0.
//    A packet in flight when reset is applied is lost. No partial state survives reset.
//  FIFO: write while full is ignored, even if a read occurs in the same cycle, and pulses overflow_err.
//    fifo_full is registered from occupancy (width $clog2(FIFO_DEPTH+1)). Pointers wrap modulo FIFO_DEPTH.
//  Request: FIFO i requests output d=head.dest when it is non-empty and d<NUM_PORTS.
//    If d>=NUM_PORTS, the head is popped, misroute_err[i] pulses, and nothing is forwarded.
//  Grant for output j is combinational and requires out_ready[j]=1.
//    Unlocked: round-robin from rr_ptr[j]. On a grant to input k, rr_ptr[j] <= (k+1)%NUM_PORTS.
//    Locked to input k: only k may be granted. Other requesters stall, even if k's FIFO is empty.
//    Lock is set on a grant of a non-tail flit and cleared on a grant of a tail flit.
//    A single-flit packet (tail on its first flit) never locks.
//  An input has exactly one destination, so at most one grant per input per cycle. A grant pops that FIFO.
//  pkt_out[j] <= granted flit with valid=1. With no grant, pkt_out[j] <= '0.
//  Latency: write at edge t -> FIFO head at t+1 -> pkt_out valid after edge t+2 (min 2 cycles).
//  Throughput: 1 flit/cycle per output. Concurrent, non-conflicting input->output pairs are all granted.
// CONFIGURATION
//  ROUTER_STATS_EN defined: adds outputs flit_cnt[NUM_PORTS][32] and pkt_cnt[NUM_PORTS][32].
//    flit_cnt counts granted flits per output. pkt_cnt counts granted tail flits per output.
//    Both counters wrap modulo 2^32 and reset to 0.
//  ROUTER_STATS_EN not defined: the ports and counters do not exist. Behaviour is otherwise identical.
// STRUCTURE
//  Package router_pkg: DATA_W=32, DEST_W=3, and
//    pkt_flit_t {valid, tail, dest[DEST_W-1:0], data[DATA_W-1:0]}.
//  Sub-module router_out_arb: one per output, holding the lock flag and rr_ptr.
//    Inputs: req[NUM_PORTS], tail[NUM_PORTS], ready. Output: one-hot grant.
//  Input FIFOs: inline generate loop in param_router.
// TESTING
//  1 Contention: NUM_PORTS=4. In0 and in2 each write a 1-flit packet to dest 1 at t, out_ready=all 1.
//    Required: pkt_out[1] = in0 flit at t+2, then in2 flit at t+3.
//  2 Wormhole: in1 sends a 3-flit packet (H,B,T) to out0 starting at t. In3 sends a 1-flit packet to out0 at t+1.
//    Required: out0 carries H,B,T at t+2..t+4 and the in3 flit at t+5, with no interleave.
//  3 Backpressure: out_ready[2]=0. In0 writes 5 flits to dest 2, FIFO_DEPTH=4.
//    Required: fifo_full[0]=1 after the 4th write, the 5th write is dropped with a one-cycle overflow_err[0].
//    Then raise out_ready[2]: the 4 stored flits drain in order.
//  4 Misroute: in1 flit with dest=6, NUM_PORTS=4.
//    Required: misroute_err[1] pulses at t+1, no pkt_out valid, and the next flit in FIFO 1 is forwarded normally.
//  5 Reset mid-packet: assert rst_b=0 after H of a 3-flit packet.
//    Required: all outputs 0 next cycle. After release, a new packet from another input is granted without waiting on the stale lock.
//  6 ROUTER_STATS_EN: send 3 packets totalling 7 flits to out3.
//    Required: flit_cnt[3]=7 and pkt_cnt[3]=3. All other counters=0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types for the parametrised wormhole router: flit layout and arbiter lock state.
package router_pkg;
   localparam int DATA_W = 32;
   localparam int DEST_W = 3;

   typedef struct packed {
      logic              valid;
      logic              tail;
      logic [DEST_W-1:0] dest;
      logic [DATA_W-1:0] data;
   } pkt_flit_t;

   typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_t;
endpackage

// File: rtl/param_router_if.sv
// Port bundle of param_router. With ROUTER_STATS_EN defined it also carries flit_cnt/pkt_cnt.
interface param_router_if import router_pkg::*; #(
   parameter int NUM_PORTS = 4
);
   pkt_flit_t            pkt_in [NUM_PORTS];
   logic [NUM_PORTS-1:0] out_ready;
   pkt_flit_t            pkt_out [NUM_PORTS];
   logic [NUM_PORTS-1:0] fifo_full;
   logic [NUM_PORTS-1:0] overflow_err;
   logic [NUM_PORTS-1:0] misroute_err;
`ifdef ROUTER_STATS_EN
   logic [31:0]          flit_cnt [NUM_PORTS];
   logic [31:0]          pkt_cnt [NUM_PORTS];

   modport master (output pkt_in, out_ready,
                   input  pkt_out, fifo_full, overflow_err, misroute_err, flit_cnt, pkt_cnt);
   modport slave  (input  pkt_in, out_ready,
                   output pkt_out, fifo_full, overflow_err, misroute_err, flit_cnt, pkt_cnt);
`else
   modport master (output pkt_in, out_ready,
                   input  pkt_out, fifo_full, overflow_err, misroute_err);
   modport slave  (input  pkt_in, out_ready,
                   output pkt_out, fifo_full, overflow_err, misroute_err);
`endif
endinterface

// File: rtl/router_out_arb.sv
// Per-output round-robin arbiter that stays locked to one input from head flit to tail flit.
module router_out_arb import router_pkg::*; #(
   parameter int NUM_PORTS = 4
) (
   input  logic                 clk,
   input  logic                 rst_b,
   input  logic [NUM_PORTS-1:0] req,
   input  logic [NUM_PORTS-1:0] tail,
   input  logic                 ready,
   output logic [NUM_PORTS-1:0] grant
);
   localparam int IDX_W = $clog2(NUM_PORTS);

   arb_state_t       state, state_next;
   logic [IDX_W-1:0] owner, owner_next;
   logic [IDX_W-1:0] rr_ptr, rr_ptr_next;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] cand;

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state  <= ARB_OPEN;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_next;
         owner  <= owner_next;
         rr_ptr <= rr_ptr_next;
      end
   end

   always_comb begin
      grant       = '0;
      gnt_idx     = '0;
      cand        = '0;
      state_next  = state;
      owner_next  = owner;
      rr_ptr_next = rr_ptr;
      if (ready) begin
         if (state == ARB_LOCKED) begin
            grant[owner] = req[owner];
            gnt_idx      = owner;
         end else begin
            // Scan from the farthest candidate back so the requester nearest rr_ptr wins.
            for (int off = NUM_PORTS - 1; off >= 0; off--) begin
               cand = IDX_W'((int'(rr_ptr) + off) % NUM_PORTS);
               if (req[cand]) begin
                  grant       = '0;
                  grant[cand] = 1'b1;
                  gnt_idx     = cand;
               end
            end
         end
      end
      if (|grant) begin
         rr_ptr_next = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
         owner_next  = gnt_idx;
         state_next  = (|(grant & tail)) ? ARB_OPEN : ARB_LOCKED;
      end
   end
endmodule

// File: rtl/param_router.sv
// NUM_PORTS x NUM_PORTS wormhole router: per-input FIFO, per-output locking round-robin arbiter.
// Define ROUTER_STATS_EN to add per-output flit_cnt/pkt_cnt counters.
module param_router import router_pkg::*; #(
   parameter int NUM_PORTS  = 4,
   parameter int FIFO_DEPTH = 4
) (
   input logic           clk,
   input logic           rst_b,
   param_router_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   pkt_flit_t            head [NUM_PORTS];
   logic [NUM_PORTS-1:0] not_empty;
   logic [NUM_PORTS-1:0] misroute;
   logic [NUM_PORTS-1:0] pop;
   logic [NUM_PORTS-1:0] gnt [NUM_PORTS];   // gnt[output][input]

   always_comb begin
      pop = misroute;
      for (int j = 0; j < NUM_PORTS; j++) pop = pop | gnt[j];
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
      pkt_flit_t        mem [FIFO_DEPTH];
      logic [PTR_W-1:0] rd_ptr, wr_ptr;
      logic [CNT_W-1:0] count, count_next;
      logic             full, wr_en, full_q, ovf_q;

      // A full FIFO refuses the write even when it is popped in the same cycle.
      assign full         = (count == CNT_W'(FIFO_DEPTH));
      assign wr_en        = bus.pkt_in[i].valid && !full;
      assign count_next   = count + CNT_W'(wr_en) - CNT_W'(pop[i]);
      assign head[i]      = mem[rd_ptr];
      assign not_empty[i] = (count != '0);
      assign misroute[i]  = not_empty[i] && (int'(head[i].dest) >= NUM_PORTS);

      // NOTE: storage has no reset; count and pointers alone decide which entries are live.
      always_ff @(posedge clk) begin
         if (wr_en) mem[wr_ptr] <= bus.pkt_in[i];
      end

      always_ff @(posedge clk) begin
         if (!rst_b) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
         end else begin
            if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
            if (pop[i]) rd_ptr <= rd_ptr + 1'b1;
            count  <= count_next;
            full_q <= (count_next == CNT_W'(FIFO_DEPTH));
            ovf_q  <= bus.pkt_in[i].valid && full;
         end
      end

      assign bus.fifo_full[i]    = full_q;
      assign bus.overflow_err[i] = ovf_q;
      assign bus.misroute_err[i] = misroute[i];
   end

   for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
      logic [NUM_PORTS-1:0] req, tail;
      pkt_flit_t            sel, out_q;

      always_comb begin
         req  = '0;
         tail = '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            req[i]  = not_empty[i] && (head[i].dest == DEST_W'(j));
            tail[i] = head[i].tail;
         end
      end

      router_out_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
         .clk   (clk),
         .rst_b (rst_b),
         .req   (req),
         .tail  (tail),
         .ready (bus.out_ready[j]),
         .grant (gnt[j])
      );

      always_comb begin
         sel = '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt[j][i]) sel = head[i];
         end
         sel.valid = |gnt[j];
      end

      always_ff @(posedge clk) begin
         if (!rst_b) out_q <= '0;
         else        out_q <= sel;
      end
      assign bus.pkt_out[j] = out_q;

`ifdef ROUTER_STATS_EN
      logic [31:0] flit_q, pkt_q;
      always_ff @(posedge clk) begin
         if (!rst_b) begin
            flit_q <= '0;
            pkt_q  <= '0;
         end else if (|gnt[j]) begin
            flit_q <= flit_q + 32'd1;
            if (sel.tail) pkt_q <= pkt_q + 32'd1;
         end
      end
      assign bus.flit_cnt[j] = flit_q;
      assign bus.pkt_cnt[j]  = pkt_q;
`endif
   end
endmodule

// File: tb/tb_param_router.sv
// Self-checking bench for param_router: directed scenarios plus random traffic against a queue model.
module tb_param_router;
   import router_pkg::*;

   localparam int NP    = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_b;
   always #5 clk = ~clk;

   param_router_if #(.NUM_PORTS(NP)) bus ();
   param_router #(.NUM_PORTS(NP), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: a queue per input, lock owner (-1 = free) and next-priority input per output.
   pkt_flit_t     q [NP][$];
   int            lock_owner [NP];
   int            rr [NP];
   pkt_flit_t     exp_out [NP];
   logic [NP-1:0] exp_full, exp_ovf;
   logic [31:0]   flit_ref [NP];
   logic [31:0]   pkt_ref [NP];
   logic [31:0]   got [$];
   int            rem [NP];
   int            dst [NP];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, want %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [63:0] fx(input pkt_flit_t f);
      return {27'b0, f};
   endfunction

   function automatic pkt_flit_t mk(input logic tail, input int dest, input logic [31:0] data);
      pkt_flit_t f;
      f.valid = 1'b1;
      f.tail  = tail;
      f.dest  = DEST_W'(dest);
      f.data  = data;
      return f;
   endfunction

   function automatic bit wants(input int k, input int j);
      return (q[k].size() > 0) && (int'(q[k][0].dest) == j);
   endfunction

   // Advance the model across one rising edge using the inputs currently applied.
   task automatic model_edge();
      pkt_flit_t     nxt [NP];
      logic [NP-1:0] popped;
      int            w;
      bit            full_before;
      popped = '0;
      if (!rst_b) begin
         for (int i = 0; i < NP; i++) begin
            q[i].delete();
            lock_owner[i] = -1;
            rr[i]         = 0;
            exp_out[i]    = '0;
            flit_ref[i]   = '0;
            pkt_ref[i]    = '0;
         end
         exp_full = '0;
         exp_ovf  = '0;
         return;
      end
      for (int j = 0; j < NP; j++) begin
         nxt[j] = '0;
         w      = -1;
         if (bus.out_ready[j]) begin
            if (lock_owner[j] >= 0) begin
               if (wants(lock_owner[j], j)) w = lock_owner[j];
            end else begin
               for (int off = 0; off < NP; off++)
                  if (w < 0 && wants((rr[j] + off) % NP, j)) w = (rr[j] + off) % NP;
            end
         end
         if (w >= 0) begin
            nxt[j]        = q[w][0];
            nxt[j].valid  = 1'b1;
            popped[w]     = 1'b1;
            rr[j]         = (w + 1) % NP;
            lock_owner[j] = q[w][0].tail ? -1 : w;
            flit_ref[j]++;
            if (q[w][0].tail) pkt_ref[j]++;
         end
      end
      for (int i = 0; i < NP; i++)
         if (q[i].size() > 0 && int'(q[i][0].dest) >= NP) popped[i] = 1'b1;
      for (int i = 0; i < NP; i++) begin
         full_before = (q[i].size() == DEPTH);
         exp_ovf[i]  = 1'b0;
         if (popped[i]) void'(q[i].pop_front());
         if (bus.pkt_in[i].valid) begin
            if (full_before) exp_ovf[i] = 1'b1;
            else             q[i].push_back(bus.pkt_in[i]);
         end
         exp_full[i] = (q[i].size() == DEPTH);
         exp_out[i]  = nxt[i];
      end
   endtask

   task automatic compare_all();
      logic [NP-1:0] exp_mis;
      for (int i = 0; i < NP; i++)
         exp_mis[i] = (q[i].size() > 0) && (int'(q[i][0].dest) >= NP);
      for (int j = 0; j < NP; j++)
         check($sformatf("pkt_out%0d", j), fx(bus.pkt_out[j]), fx(exp_out[j]));
      check("fifo_full", 64'(bus.fifo_full), 64'(exp_full));
      check("overflow_err", 64'(bus.overflow_err), 64'(exp_ovf));
      check("misroute_err", 64'(bus.misroute_err), 64'(exp_mis));
`ifdef ROUTER_STATS_EN
      for (int j = 0; j < NP; j++) begin
         check($sformatf("flit_cnt%0d", j), 64'(bus.flit_cnt[j]), 64'(flit_ref[j]));
         check($sformatf("pkt_cnt%0d", j), 64'(bus.pkt_cnt[j]), 64'(pkt_ref[j]));
      end
`endif
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      compare_all();
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < NP; i++) bus.pkt_in[i] = '0;
   endtask

   task automatic random_inputs();
      pkt_flit_t f;
      for (int i = 0; i < NP; i++) begin
         bus.pkt_in[i] = '0;
         if ($urandom_range(0, 9) < 6) begin
            if (rem[i] == 0) begin
               rem[i] = $urandom_range(1, 4);
               dst[i] = ($urandom_range(0, 15) == 0) ? $urandom_range(NP, 7) : $urandom_range(0, NP - 1);
            end
            f = mk(rem[i] == 1, dst[i], $urandom());
            if (!bus.fifo_full[i] || $urandom_range(0, 3) == 0) bus.pkt_in[i] = f;
            if (!bus.fifo_full[i]) rem[i]--;
         end
      end
      for (int j = 0; j < NP; j++) bus.out_ready[j] = ($urandom_range(0, 3) != 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_b = 1'b0;
      idle_inputs();
      bus.out_ready = '1;
      for (int i = 0; i < NP; i++) begin
         rem[i] = 0;
         dst[i] = 0;
      end
      tick();
      tick();
      rst_b = 1'b1;
      tick();

      // Contention: in0 and in2 race for out1; in0 wins first from rr_ptr=0.
      bus.pkt_in[0] = mk(1'b1, 1, 32'hA0);
      bus.pkt_in[2] = mk(1'b1, 1, 32'hA2);
      tick();
      idle_inputs();
      tick();
      check("contention_first", fx(bus.pkt_out[1]), fx(mk(1'b1, 1, 32'hA0)));
      tick();
      check("contention_second", fx(bus.pkt_out[1]), fx(mk(1'b1, 1, 32'hA2)));
      tick();
      check("contention_idle", fx(bus.pkt_out[1]), 64'd0);

      // Wormhole: in3's single flit must wait behind in1's locked 3-flit packet.
      bus.pkt_in[1] = mk(1'b0, 0, 32'hB0);
      tick();
      idle_inputs();
      bus.pkt_in[1] = mk(1'b0, 0, 32'hB1);
      bus.pkt_in[3] = mk(1'b1, 0, 32'hD3);
      tick();
      check("wormhole_head", fx(bus.pkt_out[0]), fx(mk(1'b0, 0, 32'hB0)));
      idle_inputs();
      bus.pkt_in[1] = mk(1'b1, 0, 32'hB2);
      tick();
      check("wormhole_body", fx(bus.pkt_out[0]), fx(mk(1'b0, 0, 32'hB1)));
      idle_inputs();
      tick();
      check("wormhole_tail", fx(bus.pkt_out[0]), fx(mk(1'b1, 0, 32'hB2)));
      tick();
      check("wormhole_in3", fx(bus.pkt_out[0]), fx(mk(1'b1, 0, 32'hD3)));

      // Backpressure: fill FIFO 0 behind a stalled out2, overflow once, then drain in order.
      bus.out_ready[2] = 1'b0;
      for (int n = 0; n < 5; n++) begin
         bus.pkt_in[0] = mk(1'b1, 2, 32'hC0 + n);
         tick();
         if (n == 3) check("bp_full_after_4", 64'(bus.fifo_full[0]), 64'd1);
         if (n == 4) check("bp_overflow_pulse", 64'(bus.overflow_err), 64'b0001);
      end
      idle_inputs();
      tick();
      check("bp_overflow_cleared", 64'(bus.overflow_err), 64'd0);
      bus.out_ready[2] = 1'b1;
      got.delete();
      for (int n = 0; n < 8; n++) begin
         tick();
         if (bus.pkt_out[2].valid) got.push_back(bus.pkt_out[2].data);
      end
      check("bp_drain_count", 64'(got.size()), 64'd4);
      for (int n = 0; n < 4 && n < got.size(); n++)
         check($sformatf("bp_drain%0d", n), 64'(got[n]), 64'(32'hC0 + n));

      // Misroute: dest 6 is dropped with a pulse, the following flit still goes out.
      bus.pkt_in[1] = mk(1'b1, 6, 32'hE0);
      tick();
      check("misroute_pulse", 64'(bus.misroute_err), 64'b0010);
      bus.pkt_in[1] = mk(1'b1, 3, 32'hE1);
      tick();
      idle_inputs();
      check("misroute_cleared", 64'(bus.misroute_err), 64'd0);
      check("misroute_no_out", 64'({bus.pkt_out[3].valid, bus.pkt_out[2].valid,
                                    bus.pkt_out[1].valid, bus.pkt_out[0].valid}), 64'd0);
      tick();
      check("misroute_next", fx(bus.pkt_out[3]), fx(mk(1'b1, 3, 32'hE1)));

      // Reset mid-packet: the lock in0 holds on out2 must not survive reset.
      bus.pkt_in[0] = mk(1'b0, 2, 32'hF0);
      tick();
      idle_inputs();
      tick();
      check("rst_head_out", fx(bus.pkt_out[2]), fx(mk(1'b0, 2, 32'hF0)));
      rst_b = 1'b0;
      bus.pkt_in[0] = mk(1'b0, 2, 32'hF1);
      tick();
      check("rst_out_cleared", fx(bus.pkt_out[2]), 64'd0);
      rst_b = 1'b1;
      idle_inputs();
      bus.pkt_in[3] = mk(1'b1, 2, 32'hF3);
      tick();
      idle_inputs();
      tick();
      check("rst_new_grant", fx(bus.pkt_out[2]), fx(mk(1'b1, 2, 32'hF3)));

`ifdef ROUTER_STATS_EN
      // Statistics: 3 packets, 7 flits into out3 from a clean reset.
      rst_b = 1'b0;
      tick();
      rst_b = 1'b1;
      bus.pkt_in[0] = mk(1'b0, 3, 32'h60);
      bus.pkt_in[1] = mk(1'b0, 3, 32'h61);
      bus.pkt_in[2] = mk(1'b0, 3, 32'h62);
      tick();
      bus.pkt_in[0] = mk(1'b0, 3, 32'h70);
      bus.pkt_in[1] = mk(1'b1, 3, 32'h71);
      bus.pkt_in[2] = mk(1'b1, 3, 32'h72);
      tick();
      idle_inputs();
      bus.pkt_in[0] = mk(1'b1, 3, 32'h80);
      tick();
      idle_inputs();
      for (int n = 0; n < 12; n++) tick();
      check("stats_flit3", 64'(bus.flit_cnt[3]), 64'd7);
      check("stats_pkt3", 64'(bus.pkt_cnt[3]), 64'd3);
      for (int j = 0; j < 3; j++) begin
         check($sformatf("stats_flit%0d_zero", j), 64'(bus.flit_cnt[j]), 64'd0);
         check($sformatf("stats_pkt%0d_zero", j), 64'(bus.pkt_cnt[j]), 64'd0);
      end
`endif

      // Random traffic with occasional misroutes, overflow probes and one mid-run reset.
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            rst_b = 1'b0;
            idle_inputs();
            for (int i = 0; i < NP; i++) rem[i] = 0;
            tick();
            rst_b = 1'b1;
         end else begin
            random_inputs();
            tick();
         end
      end
      idle_inputs();
      bus.out_ready = '1;
      for (int n = 0; n < 30; n++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
